// File: rtl/lstm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : lstm_sequencer
//  Purpose  : Drives one lstm cell over a sample sequence: config loading,
//             sample issue, result buffering. Optional LSTM_SEQ_WATCHDOG_EN.
//  Revision : 1.0  initial release
// ============================================================================
module lstm_sequencer #(
    parameter int WIDTH     = 16,
    parameter int OUT_DEPTH = 4,
    parameter int TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_wr,
    input  logic [3:0]           cfg_addr,
    input  logic [WIDTH-1:0]     cfg_data,
    output logic                 cfg_ack,
    input  logic [WIDTH-1:0]     h0,
    input  logic [WIDTH-1:0]     c0,
    input  logic [WIDTH-1:0]     s_x,
    input  logic                 s_valid,
    input  logic                 s_last,
    output logic                 s_ready,
    output logic [WIDTH-1:0]     m_y,
    output logic [WIDTH-1:0]     m_c,
    output logic                 m_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    input  logic                 lstm_ready,
    input  logic                 lstm_valid,
    input  logic [WIDTH-1:0]     lstm_y,
    input  logic [WIDTH-1:0]     lstm_c,
    output logic [4*WIDTH-1:0]   weight_x,
    output logic [4*WIDTH-1:0]   weight_h,
    output logic [4*WIDTH-1:0]   bias_x,
    output logic [4*WIDTH-1:0]   bias_h,
    output logic [3:0]           weight_x_valid,
    output logic [3:0]           weight_h_valid,
    output logic [3:0]           bias_x_valid,
    output logic [3:0]           bias_h_valid,
    output logic [WIDTH-1:0]     x_in,
    output logic [WIDTH-1:0]     h_in,
    output logic [WIDTH-1:0]     C_in,
    output logic                 x_in_valid,
    output logic                 h_in_valid,
    output logic                 C_in_valid,
    output logic [15:0]          step_cnt,
    output logic                 err
);
    localparam int AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 last_q, last_d;
    logic [15:0]          step_q, step_d;
    logic [WIDTH-1:0]     fifo_y_q [OUT_DEPTH];
    logic [WIDTH-1:0]     fifo_c_q [OUT_DEPTH];
    logic [OUT_DEPTH-1:0] fifo_l_q;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     m_y_q, m_y_d, m_c_q, m_c_d;
    logic                 m_last_q, m_last_d, m_valid_q, m_valid_d;

    logic                 in_idle, cfg_ok, issue, push, pop, wd_expire;
    logic [3:0]           lane;

    assign in_idle = (state_q == ST_IDLE);
    assign cfg_ok  = in_idle && cfg_wr && lstm_ready;
    assign s_ready = (in_idle || state_q == ST_RUN) && lstm_ready
                     && (cnt_q < CW'(OUT_DEPTH)) && !(in_idle && cfg_wr);
    assign issue   = s_ready && s_valid;
    assign push    = (state_q == ST_WAIT) && lstm_valid;
    assign pop     = m_valid_q && m_ready;

    // Config value is broadcast on every lane; only the addressed lane strobes.
    assign lane           = 4'b0001 << cfg_addr[1:0];
    assign cfg_ack        = cfg_ok;
    assign weight_x       = (cfg_ok && cfg_addr[3:2] == 2'd0) ? {4{cfg_data}} : '0;
    assign weight_h       = (cfg_ok && cfg_addr[3:2] == 2'd1) ? {4{cfg_data}} : '0;
    assign bias_x         = (cfg_ok && cfg_addr[3:2] == 2'd2) ? {4{cfg_data}} : '0;
    assign bias_h         = (cfg_ok && cfg_addr[3:2] == 2'd3) ? {4{cfg_data}} : '0;
    assign weight_x_valid = (cfg_ok && cfg_addr[3:2] == 2'd0) ? lane : 4'b0000;
    assign weight_h_valid = (cfg_ok && cfg_addr[3:2] == 2'd1) ? lane : 4'b0000;
    assign bias_x_valid   = (cfg_ok && cfg_addr[3:2] == 2'd2) ? lane : 4'b0000;
    assign bias_h_valid   = (cfg_ok && cfg_addr[3:2] == 2'd3) ? lane : 4'b0000;

    assign x_in       = issue ? s_x : '0;
    assign x_in_valid = issue;
    assign h_in       = (issue && in_idle) ? h0 : '0;
    assign C_in       = (issue && in_idle) ? c0 : '0;
    assign h_in_valid = issue && in_idle;
    assign C_in_valid = issue && in_idle;

    assign m_y      = m_y_q;
    assign m_c      = m_c_q;
    assign m_last   = m_last_q;
    assign m_valid  = m_valid_q;
    assign step_cnt = step_q;

`ifdef LSTM_SEQ_WATCHDOG_EN
    logic [4:0] wd_q;
    logic       err_q;

    assign wd_expire = (state_q == ST_WAIT) && !lstm_valid && (wd_q == 5'(TIMEOUT - 1));
    assign err       = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (issue) begin
                wd_q <= '0;
            end else if (state_q == ST_WAIT && wd_q != 5'h1F) begin
                wd_q <= wd_q + 5'd1;
            end
            if (wd_expire) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign wd_expire = 1'b0;
    assign err       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        step_d  = step_q;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (issue) begin
                    state_d = ST_WAIT;
                    last_d  = s_last;
                    if (step_q != 16'hFFFF) begin
                        step_d = step_q + 16'd1;
                    end
                end
            end
            ST_WAIT: begin
                if (lstm_valid) begin
                    if (last_q) begin
                        state_d = ST_IDLE;
                        step_d  = '0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (wd_expire) begin
                    state_d = ST_ERR;
                end
            end
            default: state_d = ST_ERR;
        endcase
    end

    // Head view looks through to the incoming result when it becomes the head.
    always_comb begin
        wr_ptr_d  = wr_ptr_q + AW'(push);
        rd_ptr_d  = rd_ptr_q + AW'(pop);
        cnt_d     = cnt_q + CW'(push) - CW'(pop);
        m_valid_d = (cnt_d != '0);
        m_y_d     = fifo_y_q[rd_ptr_d];
        m_c_d     = fifo_c_q[rd_ptr_d];
        m_last_d  = fifo_l_q[rd_ptr_d];
        if (push && wr_ptr_q == rd_ptr_d) begin
            m_y_d    = lstm_y;
            m_c_d    = lstm_c;
            m_last_d = last_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            last_q    <= 1'b0;
            step_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            fifo_l_q  <= '0;
            m_y_q     <= '0;
            m_c_q     <= '0;
            m_last_q  <= 1'b0;
            m_valid_q <= 1'b0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                fifo_y_q[i] <= '0;
                fifo_c_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            step_q    <= step_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            m_y_q     <= m_y_d;
            m_c_q     <= m_c_d;
            m_last_q  <= m_last_d;
            m_valid_q <= m_valid_d;
            if (push) begin
                fifo_y_q[wr_ptr_q] <= lstm_y;
                fifo_c_q[wr_ptr_q] <= lstm_c;
                fifo_l_q[wr_ptr_q] <= last_q;
            end
        end
    end
endmodule
`default_nettype wire

// File: doc/lstm_sequencer.md
# lstm_sequencer

Initiator-side controller that drives one `lstm` cell over a sequence of time steps. It loads weights and biases through a narrow config port. It then streams input samples into the cell one at a time, honouring the cell's `ready`. The first step of each sequence is seeded with initial hidden/cell state, and later steps use the cell's internal feedback. It buffers each `(y_out, C_out)` result into an output FIFO with valid/ready backpressure. It sits between the sample source and the cell, and between the cell and downstream consumers.

## Interface
- `WIDTH`, 16: sample/weight width, signed Q8.8.
- `OUT_DEPTH`, 4: output FIFO depth; power of two, ≥2.
- `TIMEOUT`, 15: watchdog limit in cycles from issue to `lstm_valid`.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `cfg_wr`  in  1  config write request.
- `cfg_addr`  in  4  config address. [3:2] selects 0=weight_x, 1=weight_h, 2=bias_x, 3=bias_h. [1:0] selects gate 0=i, 1=f, 2=g, 3=o.
- `cfg_data`  in  WIDTH  config value.
- `cfg_ack`  out  1  write accepted this cycle.
- `h0`, `c0`  in  WIDTH each  initial hidden/cell state, sampled at the first step of a sequence.
- `s_x`, `s_valid`, `s_last`  in  WIDTH/1/1  input sample stream; `s_last` marks the final step.
- `s_ready`  out  1  sample accepted when `s_valid && s_ready`.
- `m_y`, `m_c`, `m_last`  out  WIDTH/WIDTH/1  result stream.
- `m_valid`  out  1  FIFO non-empty.
- `m_ready`  in  1  consumer pops when `m_valid && m_ready`.
- `lstm_ready`, `lstm_valid`  in  1 each  from the cell.
- `lstm_y`, `lstm_c`  in  WIDTH each  cell `y_out`, `C_out`.
- `weight_x`, `weight_h`, `bias_x`, `bias_h`  out  4×WIDTH each  config data to the cell.
- `weight_x_valid`, `weight_h_valid`, `bias_x_valid`, `bias_h_valid`  out  4 each  one-hot lane strobes.
- `x_in`, `h_in`, `C_in`  out  WIDTH each  datapath to the cell.
- `x_in_valid`, `h_in_valid`, `C_in_valid`  out  1 each  datapath strobes.
- `step_cnt`  out  16  steps issued in the current sequence.
- `err`  out  1  watchdog fault, sticky.

## Operation
- FSM states are IDLE, RUN, WAIT and ERR. Reset enters IDLE.
- IDLE handles config and the first step.
  - `cfg_ack = cfg_wr && lstm_ready`.
  - On ack, `cfg_data` is broadcast on all four lanes of the bus selected by `cfg_addr[3:2]`. Only lane `cfg_addr[1:0]` of that bus's valid vector pulses for one cycle.
  - A config write has priority over the stream: `s_ready` is 0 in any cycle where `cfg_wr` is 1.
- Issue condition: `s_ready = (IDLE || RUN) && lstm_ready && fifo_cnt < OUT_DEPTH && !(IDLE && cfg_wr)`.
  - On handshake, `x_in = s_x` and `x_in_valid = 1` combinationally, for one cycle.
  - In IDLE, the same cycle also drives `h_in = h0`, `C_in = c0` and `h_in_valid = C_in_valid = 1`.
  - In RUN, `h_in_valid` and `C_in_valid` stay 0 so the cell uses its own feedback.
- On issue: capture `s_last` into `last_q`, increment `step_cnt`, clear the watchdog, and go to WAIT.
- WAIT exits on `lstm_valid`:
  - Push `{lstm_y, lstm_c, last_q}` into the FIFO. Space is guaranteed by the issue condition, because only one step is ever outstanding.
  - If `last_q` is set, go to IDLE and clear `step_cnt`; otherwise go to RUN.
- `lstm_valid` is ignored outside WAIT.
- FIFO details:
  - Circular buffer with wrapping pointers and `fifo_cnt` ranging 0..OUT_DEPTH.
  - A push and a pop in the same cycle leave `fifo_cnt` unchanged.
  - Outputs are registered from the head entry.
- `step_cnt` saturates at 0xFFFF.

## Timing
- Registered outputs reset to 0: `m_y`, `m_c`, `m_last`, `m_valid`, `step_cnt`, `err`, and all FIFO state.
- Combinational outputs (`s_ready`, `cfg_ack`, cell strobes) evaluate with state = IDLE after reset.
- Issue to cell: 0 cycles. The cell asserts `lstm_valid` 7 cycles after `x_in_valid`.
- `lstm_valid` to `m_valid`: 1 cycle when the FIFO was empty.
- Step throughput is one per 8 cycles minimum: 7 cycles in WAIT plus 1 issue cycle.
- A full FIFO holds `s_ready` at 0. Issue resumes the cycle after the pop that brings `fifo_cnt` below `OUT_DEPTH`.
- Asserting `rst_n` low mid-step returns to IDLE immediately, empties the FIFO, and drops any in-flight result.

## Configuration
- `LSTM_SEQ_WATCHDOG_EN` defined:
  - A 5-bit counter runs in WAIT.
  - When the count reaches `TIMEOUT` without `lstm_valid`, the FSM enters ERR and sets `err = 1`.
  - In ERR, `s_ready = 0` and `cfg_ack = 0`.
  - Only reset exits ERR.
- `LSTM_SEQ_WATCHDOG_EN` undefined: no counter, the ERR state is unreachable, `err` is tied to 0, and WAIT waits indefinitely.

## Test plan
- Config write: `cfg_addr = 4'b0110`, `cfg_data = 0x0080`, `lstm_ready = 1`.
  - Required: `cfg_ack = 1` and `weight_h_valid = 4'b0100` for one cycle.
  - All `weight_h` lanes carry 0x0080.
- Three-step sequence: `x = 0x0100, 0x0080, 0xFF00` with `h0 = 0x0040`, `c0 = 0x0020`.
  - Required: `h_in_valid`/`C_in_valid` pulse on step 1 only.
  - Results appear in order, `m_last` is set on the third, and `step_cnt` goes 1, 2, 3, then 0.
- Backpressure: `OUT_DEPTH = 4` with `m_ready = 0` and 6 samples offered.
  - Required: exactly 4 issued and `s_ready` held at 0.
  - After 1 pop, the 5th issues the next cycle.
- Simultaneous `cfg_wr` and `s_valid` in IDLE.
  - Required: config acked, no issue that cycle; the sample issues the following cycle.
- With `LSTM_SEQ_WATCHDOG_EN`: `lstm_valid` withheld after issue.
  - Required: `err = 1` after 15 WAIT cycles, `s_ready` stays 0 until `rst_n` is pulsed low.
- Reset mid-WAIT.
  - Required: `m_valid = 0`, `step_cnt = 0`, and a following `lstm_valid` is ignored.
